// File: rtl/axi_slave_pkg.sv
// Shared encodings and state types for the AXI3 slave RAM.
package axi_slave_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_64 = 3'b011;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  // WRAP and reserved bursts are still walked as INCR but flagged as errors.
  function automatic logic addr_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_64) || burst[1];
  endfunction
endpackage

// File: rtl/axi_slave_byte_ram.sv
// 64-bit word RAM with per-byte write enables and a registered, load-enabled read port.
module axi_slave_byte_ram #(
  parameter int unsigned WORD_AW = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [WORD_AW-1:0] waddr_i,
  input  logic [63:0]        wdata_i,
  input  logic [7:0]         wstrb_i,
  input  logic               re_i,
  input  logic [WORD_AW-1:0] raddr_i,
  output logic [63:0]        rdata_o
);
  localparam int unsigned DEPTH = 2 ** WORD_AW;

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  // Array is deliberately unreset so contents survive a bus reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_slave_ram.sv
// AXI3 64-bit slave backed by a byte-lane RAM; independent write and read FSMs.
module axi_slave_ram
  import axi_slave_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned RAM_ADDR_WIDTH = 7
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_WIDTH-1:0] AWID,
  input  logic [31:0]         AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ID_WIDTH-1:0] WID,
  input  logic [63:0]         WDATA,
  input  logic [7:0]          WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_WIDTH-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_WIDTH-1:0] ARID,
  input  logic [31:0]         ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_WIDTH-1:0] RID,
  output logic [63:0]         RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);
  localparam int unsigned WA = RAM_ADDR_WIDTH - 3;

  wstate_e             wstate_q, wstate_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [WA-1:0]       waddr_q, waddr_d;
  logic [3:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic                werr_q, werr_d, wfixed_q, wfixed_d;

  rstate_e             rstate_q, rstate_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [WA-1:0]       raddr_q, raddr_d;
  logic [3:0]          rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic                rerr_q, rerr_d, rfixed_q, rfixed_d;

  logic                ram_we, ram_re;
  logic [WA-1:0]       ram_raddr;

  logic unused_ok;
  assign unused_ok = ^{WID, AWADDR[31:RAM_ADDR_WIDTH], AWADDR[2:0],
                       ARADDR[31:RAM_ADDR_WIDTH], ARADDR[2:0]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
      bid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
      wfixed_q <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      bid_q    <= bid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      wfixed_q <= wfixed_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    bid_d    = bid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    wfixed_d = wfixed_q;
    ram_we   = 1'b0;
    unique case (wstate_q)
      W_IDLE: if (AWVALID) begin
        bid_d    = AWID;
        waddr_d  = AWADDR[RAM_ADDR_WIDTH-1:3];
        wlen_d   = AWLEN;
        wcnt_d   = '0;
        werr_d   = addr_err(AWSIZE, AWBURST);
        wfixed_d = (AWBURST == BURST_FIXED);
        wstate_d = W_DATA;
      end
      W_DATA: if (WVALID) begin
        ram_we = 1'b1;
        wcnt_d = wcnt_q + 4'd1;
        if (!wfixed_q) waddr_d = waddr_q + WA'(1);
        if (WLAST != (wcnt_q == wlen_q)) werr_d = 1'b1;
        if (wcnt_q == wlen_q) wstate_d = W_RESP;
      end
      W_RESP: if (BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  assign AWREADY = (wstate_q == W_IDLE);
  assign WREADY  = (wstate_q == W_DATA);
  assign BVALID  = (wstate_q == W_RESP);
  assign BID     = bid_q;
  assign BRESP   = werr_q ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rerr_q   <= 1'b0;
      rfixed_q <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rerr_q   <= rerr_d;
      rfixed_q <= rfixed_d;
    end
  end

  // The read register is loaded one beat ahead: on AR, and on each non-final R handshake.
  always_comb begin
    rstate_d  = rstate_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    rfixed_d  = rfixed_q;
    ram_re    = 1'b0;
    ram_raddr = raddr_q;
    unique case (rstate_q)
      R_IDLE: if (ARVALID) begin
        rid_d     = ARID;
        raddr_d   = ARADDR[RAM_ADDR_WIDTH-1:3];
        rlen_d    = ARLEN;
        rcnt_d    = '0;
        rerr_d    = addr_err(ARSIZE, ARBURST);
        rfixed_d  = (ARBURST == BURST_FIXED);
        ram_re    = 1'b1;
        ram_raddr = ARADDR[RAM_ADDR_WIDTH-1:3];
        rstate_d  = R_DATA;
      end
      R_DATA: if (RREADY) begin
        if (rcnt_q == rlen_q) begin
          rstate_d = R_IDLE;
        end else begin
          rcnt_d    = rcnt_q + 4'd1;
          raddr_d   = rfixed_q ? raddr_q : raddr_q + WA'(1);
          ram_re    = 1'b1;
          ram_raddr = raddr_d;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign ARREADY = (rstate_q == R_IDLE);
  assign RVALID  = (rstate_q == R_DATA);
  assign RID     = rid_q;
  assign RRESP   = rerr_q ? RESP_SLVERR : RESP_OKAY;
  assign RLAST   = (rstate_q == R_DATA) && (rcnt_q == rlen_q);

  axi_slave_byte_ram #(.WORD_AW(WA)) u_ram (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .we_i    (ram_we),
    .waddr_i (waddr_q),
    .wdata_i (WDATA),
    .wstrb_i (WSTRB),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (RDATA)
  );
endmodule

// File: tb/tb_axi_slave_ram.sv
// Scoreboard bench for axi_slave_ram: directed bursts, shadow byte model, B/R monitors.
module tb_axi_slave_ram;
  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  AWID = '0, WID = '0, ARID = '0;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic [3:0]  AWLEN = '0, ARLEN = '0;
  logic [2:0]  AWSIZE = 3'd3, ARSIZE = 3'd3;
  logic [1:0]  AWBURST = 2'b01, ARBURST = 2'b01;
  logic        AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, ARVALID = 1'b0;
  logic [63:0] WDATA = '0;
  logic [7:0]  WSTRB = '0;
  logic        BREADY = 1'b1, RREADY = 1'b1;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
  logic [3:0]  BID, RID;
  logic [1:0]  BRESP, RRESP;
  logic [63:0] RDATA;

  axi_slave_ram #(.ID_WIDTH(4), .RAM_ADDR_WIDTH(7)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];
  logic [7:0] mdl [128];
  int errors = 0;
  int checks = 0;
  bit rpulse = 1'b0;
  int rcyc = 0;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic logic [63:0] mword(input logic [3:0] w);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = mdl[int'(w)*8 + i];
    return d;
  endfunction

  function automatic logic [63:0] gdata(input int seed, input int k);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(seed * 37 + k * 8 + i + 1);
    return d;
  endfunction

  // Monitors: compare every presented B/R against the head of its queue, pop on handshake.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (BVALID) begin
        if (bq.size() == 0) bound_fail("b_unexpected");
        else begin
          chk("bid", BID, bq[0].id);
          chk("bresp", BRESP, bq[0].resp);
          if (BREADY) void'(bq.pop_front());
        end
      end
      if (RVALID) begin
        if (rq.size() == 0) bound_fail("r_unexpected");
        else begin
          chk("rid", RID, rq[0].id);
          chk("rdata", RDATA, rq[0].data);
          chk("rresp", RRESP, rq[0].resp);
          chk("rlast", RLAST, rq[0].last);
          if (RREADY) void'(rq.pop_front());
        end
      end
    end
  end

  always @(posedge ACLK) begin
    #1;
    rcyc++;
    RREADY = rpulse ? (rcyc % 4 == 0) : 1'b1;
  end

  task automatic aw_issue(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n == 50) bound_fail("aw_timeout");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n == 50) bound_fail("ar_timeout");
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l, input logic [3:0] w);
    int n = 0;
    WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n == 50) bound_fail("w_timeout");
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    for (int i = 0; i < 8; i++) if (s[i]) mdl[int'(w)*8 + i] = d[i*8 +: 8];
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int early,
                          input logic [1:0] resp, input bit sweep, input int seed);
    logic [3:0] w;
    logic [7:0] s;
    logic l;
    bq.push_back('{id: id, resp: resp});
    aw_issue(id, a, len, size, burst);
    w = a[6:3];
    for (int k = 0; k <= int'(len); k++) begin
      s = 8'hFF;
      if (sweep) begin
        if (k == 0) s = 8'hFE;
        else if (k == int'(len)) s = 8'h7F;
      end
      l = (early >= 0) ? (k == early) : (k == int'(len));
      w_beat(gdata(seed, k), s, l, w);
      if (burst != 2'b00) w = w + 4'd1;
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
    logic [3:0] w = a[6:3];
    for (int k = 0; k <= int'(len); k++) begin
      rq.push_back('{id: id, data: mword(w), resp: resp, last: (k == int'(len))});
      if (burst != 2'b00) w = w + 4'd1;
    end
    ar_issue(id, a, len, size, burst);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 300) begin @(negedge ACLK); n++; end
    if (n == 300) bound_fail(name);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 1); chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);   chk("rst_arready", ARREADY, 1);
    chk("rst_rvalid", RVALID, 0);   chk("rst_rdata", RDATA, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // W beats offered before any AW must be ignored.
    WVALID = 1'b1; WLAST = 1'b1; WSTRB = 8'hFF;
    for (int i = 0; i < 3; i++) begin @(negedge ACLK); chk("wready_idle", WREADY, 0); end
    @(posedge ACLK); #1;
    WVALID = 1'b0;

    // Zero fill all 16 words.
    bq.push_back('{id: 4'd0, resp: OKAY});
    aw_issue(4'd0, 32'h0, 4'd15, 3'd3, 2'b01);
    for (int k = 0; k < 16; k++) w_beat(64'h0, 8'hFF, k == 15, 4'(k));
    drain("fill");

    // Single beat with partial strobe, hand-computed readback.
    bq.push_back('{id: 4'd6, resp: OKAY});
    aw_issue(4'd6, 32'h01, 4'd0, 3'd3, 2'b01);
    w_beat(64'h1122334455667788, 8'h7E, 1'b1, 4'd0);
    drain("single_w");
    rq.push_back('{id: 4'd6, data: 64'h0022334455667700, resp: OKAY, last: 1'b1});
    ar_issue(4'd6, 32'h00, 4'd0, 3'd3, 2'b01);
    drain("single_r");

    for (int ln = 1; ln <= 15; ln++) begin
      do_write(4'(ln), 32'h01, 4'(ln), 3'd3, 2'b01, -1, OKAY, 1'b1, ln);
      drain("sweep_w");
      do_read(4'(ln), 32'h01, 4'(ln), 3'd3, 2'b01, OKAY);
      drain("sweep_r");
    end

    // Backpressure on B, then throttled R.
    BREADY = 1'b0;
    do_write(4'd8, 32'h08, 4'd3, 3'd3, 2'b01, -1, OKAY, 1'b0, 50);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bp_bvalid", BVALID, 1);
      chk("bp_awready", AWREADY, 0);
    end
    @(posedge ACLK); #1;
    BREADY = 1'b1;
    drain("bp_b");
    rpulse = 1'b1;
    do_read(4'd9, 32'h08, 4'd7, 3'd3, 2'b01, OKAY);
    drain("bp_r");
    rpulse = 1'b0;

    // Error responses with full beat counts.
    do_write(4'd1, 32'h10, 4'd1, 3'd2, 2'b01, -1, SLVERR, 1'b0, 60);
    drain("err_size");
    do_read(4'd2, 32'h08, 4'd3, 3'd3, 2'b10, SLVERR);
    drain("err_wrap");
    do_write(4'd4, 32'h30, 4'd3, 3'd3, 2'b01, 1, SLVERR, 1'b0, 70);
    drain("err_wlast");
    do_read(4'd4, 32'h30, 4'd3, 3'd3, 2'b01, OKAY);
    drain("err_wlast_r");

    // Address wrap-around and FIXED bursts.
    do_write(4'd5, 32'h70, 4'd3, 3'd3, 2'b01, -1, OKAY, 1'b0, 80);
    drain("wrap_w");
    do_read(4'd5, 32'h70, 4'd3, 3'd3, 2'b01, OKAY);
    drain("wrap_r");
    do_write(4'd7, 32'h20, 4'd2, 3'd3, 2'b00, -1, OKAY, 1'b0, 90);
    drain("fixed_w");
    do_read(4'd7, 32'h20, 4'd1, 3'd3, 2'b01, OKAY);
    drain("fixed_r");
    do_read(4'd7, 32'h20, 4'd2, 3'd3, 2'b00, OKAY);
    drain("fixed_rf");

    // Reset after two beats of an 8-beat write; no B may follow.
    aw_issue(4'd3, 32'h40, 4'd7, 3'd3, 2'b01);
    w_beat(64'hDEADBEEF00000000, 8'hFF, 1'b0, 4'd8);
    w_beat(64'hDEADBEEF00000001, 8'hFF, 1'b0, 4'd9);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("mid_awready", AWREADY, 1); chk("mid_wready", WREADY, 0);
    chk("mid_bvalid", BVALID, 0);   chk("mid_bid", BID, 0);
    chk("mid_bresp", BRESP, 0);     chk("mid_arready", ARREADY, 1);
    chk("mid_rvalid", RVALID, 0);   chk("mid_rid", RID, 0);
    chk("mid_rdata", RDATA, 0);     chk("mid_rresp", RRESP, 0);
    chk("mid_rlast", RLAST, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge ACLK); chk("post_rst_bvalid", BVALID, 0); end
    do_read(4'd3, 32'h40, 4'd7, 3'd3, 2'b01, OKAY);
    drain("rst_r");

    repeat (3) @(negedge ACLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
